ex_muldiv_ctrl: RTL and testbench

//  Iterative RV32M multiply/divide unit plus its sequencer, placed beside the EX-stage ALU.

---
 rtl/ex_muldiv_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_ex_muldiv_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: iterative RV32M multiply/divide unit with its sequencer.
// It sits beside the EX-stage ALU. The pipeline is stalled while the unit runs a
// radix-2 shift-add multiply or a restoring divide, one bit per cycle.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous, active-high reset
//   md_start   ID/EX holds a valid M-extension op this cycle
//   md_funct3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//              100 DIV, 101 DIVU, 110 REM, 111 REMU
//   md_a/md_b  rs1/rs2 operands; captured when the op starts
//   md_flush   kills the in-flight op; returns to IDLE next cycle
//   md_stall   holds the IF/ID/EX registers
//   md_done    one-cycle pulse; md_result is valid in that cycle
//   md_result  product/quotient/remainder selected by funct3; held between ops
//
// Optional feature: define MULDIV_EARLY_OUT_EN to give zero operands a
// one-cycle early out. The results are identical whether or not it is defined.
module ex_muldiv_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            md_start,
  input  logic [2:0]      md_funct3,
  input  logic [XLEN-1:0] md_a,
  input  logic [XLEN-1:0] md_b,
  input  logic            md_flush,
  output logic            md_stall,
  output logic            md_done,
  output logic [XLEN-1:0] md_result
);

  localparam int unsigned    CW       = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]  CNT_INIT = CW'(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q;
  logic [2:0]      funct3_q;
  logic            sign_a_q, sign_b_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] acc_hi_q, acc_lo_q, op_b_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  // Decode of the incoming op; used only in IDLE.
  logic            is_div_in, a_signed_in, b_signed_in, sa_in, sb_in;
  logic [XLEN-1:0] a_mag_in, b_mag_in;
  logic            special_in;
  logic [XLEN-1:0] special_res;

  always_comb begin
    is_div_in   = md_funct3[2];
    a_signed_in = (md_funct3 == 3'b001) || (md_funct3 == 3'b010) ||
                  (md_funct3 == 3'b100) || (md_funct3 == 3'b110);
    b_signed_in = (md_funct3 == 3'b001) || (md_funct3 == 3'b100) ||
                  (md_funct3 == 3'b110);
    sa_in       = a_signed_in & md_a[XLEN-1];
    sb_in       = b_signed_in & md_b[XLEN-1];
    a_mag_in    = sa_in ? -md_a : md_a;
    b_mag_in    = sb_in ? -md_b : md_b;

    special_in  = 1'b0;
    special_res = '0;
    if (is_div_in) begin
      if (md_b == '0) begin
        special_in  = 1'b1;
        special_res = md_funct3[1] ? md_a : '1;
      end else if (!md_funct3[0] && md_a == INT_MIN && md_b == '1) begin
        special_in  = 1'b1;
        special_res = md_funct3[1] ? '0 : md_a;
      end
`ifdef MULDIV_EARLY_OUT_EN
      else if (md_a == '0) begin
        special_in  = 1'b1;
        special_res = '0;
      end
`endif
    end else begin
`ifdef MULDIV_EARLY_OUT_EN
      if (md_a == '0 || md_b == '0) begin
        special_in  = 1'b1;
        special_res = '0;
      end
`endif
    end
  end

  // One iteration step. The multiplier uses acc_hi as the running partial
  // product and acc_lo as the multiplier shifting out. The divider uses acc_hi
  // as the partial remainder and acc_lo as the dividend shifting out while
  // quotient bits shift in.
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ok;
  logic [XLEN-1:0]   step_hi, step_lo;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, op_b_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, op_b_q};
    div_ok    = ~div_diff[XLEN];
    if (funct3_q[2]) begin
      step_hi = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      step_lo = {acc_lo_q[XLEN-2:0], div_ok};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], acc_lo_q[XLEN-1:1]};
    end

    prod     = {step_hi, step_lo};
    prod_fix = (sign_a_q ^ sign_b_q) ? -prod : prod;
    quo_fix  = (sign_a_q ^ sign_b_q) ? -step_lo : step_lo;
    rem_fix  = sign_a_q ? -step_hi : step_hi;

    case (funct3_q)
      3'b000:                 final_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = quo_fix;
      default:                final_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      funct3_q <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      op_b_q   <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (md_flush) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (md_start) begin
              funct3_q <= md_funct3;
              sign_a_q <= sa_in;
              sign_b_q <= sb_in;
              cnt_q    <= CNT_INIT;
              acc_hi_q <= '0;
              acc_lo_q <= is_div_in ? a_mag_in : b_mag_in;
              op_b_q   <= is_div_in ? b_mag_in : a_mag_in;
              if (special_in) begin
                result_q <= special_res;
                done_q   <= 1'b1;
                state_q  <= DONE;
              end else begin
                state_q  <= BUSY;
              end
            end
          end
          BUSY: begin
            acc_hi_q <= step_hi;
            acc_lo_q <= step_lo;
            cnt_q    <= cnt_q - 1'b1;
            // The last step is folded into the sign correction, so the result
            // is registered on the same edge that enters DONE.
            if (cnt_q == CW'(1)) begin
              result_q <= final_res;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign md_stall  = ~md_flush & ((state_q == IDLE && md_start) || state_q == BUSY);
  assign md_done   = done_q;
  assign md_result = result_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
module tb_ex_muldiv_ctrl;

  logic        clk;
  logic        rst;
  logic        md_start;
  logic [2:0]  md_funct3;
  logic [31:0] md_a, md_b;
  logic        md_flush;
  logic        md_stall, md_done;
  logic [31:0] md_result;

  int checks = 0;
  int errors = 0;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = 33;
`endif

  ex_muldiv_ctrl #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .md_start  (md_start),
    .md_funct3 (md_funct3),
    .md_a      (md_a),
    .md_b      (md_b),
    .md_flush  (md_flush),
    .md_stall  (md_stall),
    .md_done   (md_done),
    .md_result (md_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Start at the next negedge (cycle 0), scramble the operands afterwards, and
  // wait a bounded number of cycles for md_done.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input int lat, input string name);
    int c;
    bit seen;
    int stall_bad;
    logic [31:0] held;
    @(negedge clk);
    md_flush = 1'b0;
    md_start = 1'b1;
    md_funct3 = f3;
    md_a = a;
    md_b = b;
    #1;
    chk({name, "_stall_c0"}, {31'd0, md_stall}, 32'd1);
    chk({name, "_done_c0"}, {31'd0, md_done}, 32'd0);
    c = 0;
    seen = 1'b0;
    stall_bad = 0;
    while (!seen && c < 60) begin
      @(negedge clk);
      c++;
      md_start = 1'b0;
      md_a = $urandom;
      md_b = $urandom;
      #1;
      if (md_done) begin
        seen = 1'b1;
        chk({name, "_latency"}, c, lat);
        chk({name, "_result"}, md_result, res);
        chk({name, "_stall_done"}, {31'd0, md_stall}, 32'd0);
      end else if (!md_stall) begin
        stall_bad++;
      end
    end
    chk({name, "_timeout"}, {31'd0, seen}, 32'd1);
    chk({name, "_stall_gap"}, stall_bad, 0);
    held = md_result;
    @(negedge clk);
    #1;
    chk({name, "_done_pulse"}, {31'd0, md_done}, 32'd0);
    chk({name, "_result_hold"}, md_result, res);
  endtask

  initial begin
    int c;
    int bad;
    rst = 1'b1;
    md_start = 1'b0;
    md_funct3 = '0;
    md_a = '0;
    md_b = '0;
    md_flush = 1'b0;

    vecs.push_back('{3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_7_m3"});
    vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu_ones"});
    vecs.push_back('{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, "mulh_ones"});
    vecs.push_back('{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu_ones"});
    vecs.push_back('{3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 33, "mulhu_2p16"});
    vecs.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh_min"});
    vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_m7_2"});
    vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_m7_2"});
    vecs.push_back('{3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div_7_m2"});
    vecs.push_back('{3'b110, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 33, "rem_7_m2"});
    vecs.push_back('{3'b101, 32'd100, 32'd7, 32'd14, 33, "divu_100_7"});
    vecs.push_back('{3'b111, 32'd100, 32'd7, 32'd2, 33, "remu_100_7"});
    vecs.push_back('{3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div_by0"});
    vecs.push_back('{3'b110, 32'd5, 32'd0, 32'd5, 1, "rem_by0"});
    vecs.push_back('{3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0"});
    vecs.push_back('{3'b111, 32'd5, 32'd0, 32'd5, 1, "remu_by0"});
    vecs.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf"});
    vecs.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, "rem_ovf"});
    vecs.push_back('{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33, "divu_big"});
    vecs.push_back('{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, "remu_big"});
    vecs.push_back('{3'b000, 32'd0, 32'd12345, 32'd0, EO_LAT, "mul_zero"});
    vecs.push_back('{3'b100, 32'd0, 32'd5, 32'd0, EO_LAT, "div_zero_dvd"});

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", {31'd0, md_stall}, 32'd0);
    chk("rst_done", {31'd0, md_done}, 32'd0);
    chk("rst_result", md_result, 32'd0);
    rst = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, vecs[i].name);

    // Flush at cycle 10 of a DIV, then a MUL starting at cycle 11
    @(negedge clk);
    md_start = 1'b1;
    md_funct3 = 3'b101;
    md_a = 32'd100;
    md_b = 32'd7;
    bad = 0;
    for (c = 1; c <= 10; c++) begin
      @(negedge clk);
      md_start = 1'b0;
      if (c == 10) md_flush = 1'b1;
      #1;
      if (md_done) bad++;
      if (c < 10 && !md_stall) bad++;
    end
    chk("flush_stall_c10", {31'd0, md_stall}, 32'd0);
    chk("flush_pre_errs", bad, 0);
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_after_flush");

    // Flush beats a simultaneous start
    @(negedge clk);
    md_start = 1'b1;
    md_flush = 1'b1;
    md_funct3 = 3'b000;
    md_a = 32'd3;
    md_b = 32'd3;
    #1;
    chk("flush_start_stall", {31'd0, md_stall}, 32'd0);
    bad = 0;
    @(negedge clk);
    md_start = 1'b0;
    md_flush = 1'b0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (md_done || md_stall) bad++;
    end
    chk("flush_start_idle", bad, 0);

    // Reset at cycle 5 of a MUL
    @(negedge clk);
    md_start = 1'b1;
    md_funct3 = 3'b000;
    md_a = 32'd9;
    md_b = 32'd9;
    for (c = 1; c <= 5; c++) begin
      @(negedge clk);
      md_start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_stall", {31'd0, md_stall}, 32'd0);
    chk("midrst_done", {31'd0, md_done}, 32'd0);
    chk("midrst_result", md_result, 32'd0);
    rst = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (md_done) bad++;
    end
    chk("midrst_no_done", bad, 0);
    run_op(3'b001, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "mulh_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
